// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO-side bundle for the FIFO write arbiter
//
// Signals:
//   req         N    per-requester write request, bit i = requester i has a word pending
//   req_data    N*B  requester i data on bits [i*B+B-1 : i*B]
//   fifo_full   1    downstream FIFO full, no write may be issued while set
//   fifo_wr     1    FIFO write strobe
//   fifo_w_data B    FIFO write data
//   ack         N    one-hot, bit i = requester i's word was written this cycle
//   owner       clog2(N) index of the currently granted requester
//   busy        1    a grant is held
//
// Modports:
//   master  the arbiter: samples requests and FIFO status, issues writes
//   slave   requesters plus FIFO: drive requests and full, observe writes

interface fifo_wr_arbiter_if #(
    parameter int B = 8,
    parameter int N = 4
);
    logic [N-1:0]         req;
    logic [N*B-1:0]       req_data;
    logic                 fifo_full;
    logic                 fifo_wr;
    logic [B-1:0]         fifo_w_data;
    logic [N-1:0]         ack;
    logic [$clog2(N)-1:0] owner;
    logic                 busy;

    modport master (
        input  req,
        input  req_data,
        input  fifo_full,
        output fifo_wr,
        output fifo_w_data,
        output ack,
        output owner,
        output busy
    );

    modport slave (
        output req,
        output req_data,
        output fifo_full,
        input  fifo_wr,
        input  fifo_w_data,
        input  ack,
        input  owner,
        input  busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding one FIFO write port
//
// Parameters:
//   B     data word width
//   N     number of requesters (N >= 2)
//   MAXB  maximum consecutive writes per grant (MAXB >= 1)
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high
//   bus    fifo_wr_arbiter_if.master: req/req_data/fifo_full in,
//          fifo_wr/fifo_w_data/ack/owner/busy out
//
// Operation: IDLE scans upward from rr_ptr for the first pending requester and
// grants it; BURST writes that requester's word every cycle the FIFO has room,
// up to MAXB words, ending early if the owner withdraws its request. Every
// return to IDLE moves rr_ptr just past the finished owner.

module fifo_wr_arbiter #(
    parameter int B    = 8,
    parameter int N    = 4,
    parameter int MAXB = 4
) (
    input  logic              clk,
    input  logic              reset,
    fifo_wr_arbiter_if.master bus
);
    localparam int OW = $clog2(N);
    localparam int CW = $clog2(MAXB + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state;
    logic [OW-1:0] rr_ptr;
    logic [OW-1:0] owner_q;
    logic [CW-1:0] burst_cnt;

    logic          grant_found;
    logic [OW-1:0] grant_idx;
    logic [OW-1:0] next_ptr;
    logic          owner_req;
    logic          wr;
    logic          last_wr;

    // First pending requester at or above rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!grant_found && bus.req[(int'(rr_ptr) + i) % N]) begin
                grant_found = 1'b1;
                grant_idx   = OW'((int'(rr_ptr) + i) % N);
            end
        end
    end

    assign owner_req = bus.req[owner_q];
    assign wr        = (state == BURST) && owner_req && !bus.fifo_full;
    // The write that brings the count to MAXB closes the burst.
    assign last_wr   = wr && (burst_cnt == CW'(MAXB - 1));
    assign next_ptr  = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner_q   <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // With no request the previous owner is kept visible.
                    if (grant_found) begin
                        owner_q   <= grant_idx;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (!owner_req) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end else if (wr) begin
                        burst_cnt <= burst_cnt + CW'(1);
                        if (last_wr) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end
                    // Owner requesting but FIFO full: hold everything.
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state, so reset clears them without a clock edge.
    assign bus.fifo_wr     = wr;
    assign bus.fifo_w_data = (state == BURST) ? bus.req_data[int'(owner_q) * B +: B] : '0;
    assign bus.ack         = wr ? (N'(1) << owner_q) : '0;
    assign bus.owner       = owner_q;
    assign bus.busy        = (state == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed vector bench for fifo_wr_arbiter

module tb_fifo_wr_arbiter;
    localparam int B    = 8;
    localparam int N    = 4;
    localparam int MAXB = 4;

    typedef struct packed {
        logic [3:0] req;
        logic       full;
        logic       wr;
        logic [7:0] data;
        logic [3:0] ack;
        logic [1:0] owner;
        logic       busy;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    vec_t vt[$];
    logic [7:0] dw [4];
    int   wcount [4];

    fifo_wr_arbiter_if #(.B(B), .N(N)) bus ();

    fifo_wr_arbiter #(.B(B), .N(N), .MAXB(MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] got_outs();
        return {bus.fifo_wr, bus.fifo_w_data, bus.ack, bus.owner, bus.busy};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {wr,data,ack,owner,busy}=%04h expected %04h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic f, input logic w, input logic [7:0] d,
                       input logic [3:0] a, input logic [1:0] o, input logic bz, input int n);
        vec_t v;
        v = '{req: r, full: f, wr: w, data: d, ack: a, owner: o, busy: bz};
        for (int k = 0; k < n; k++) vt.push_back(v);
    endtask

    initial begin
        logic [15:0] exp;
        int ph;
        int g;
        int og;

        total = 0;
        bad   = 0;
        dw[0] = 8'hA5; dw[1] = 8'hB1; dw[2] = 8'hC2; dw[3] = 8'hD3;
        for (int k = 0; k < 4; k++) wcount[k] = 0;

        // Burst of 4 for requester 0, rr_ptr -> 1
        add(4'b0001, 0, 0, 8'h00, 4'b0000, 2'd0, 0, 1);
        add(4'b0001, 0, 1, 8'hA5, 4'b0001, 2'd0, 1, 4);
        // rr_ptr=1 picks requester 1; full stall after 2 writes
        add(4'b0011, 0, 0, 8'h00, 4'b0000, 2'd0, 0, 1);
        add(4'b0011, 0, 1, 8'hB1, 4'b0010, 2'd1, 1, 2);
        add(4'b0011, 1, 0, 8'hB1, 4'b0000, 2'd1, 1, 3);
        add(4'b0011, 0, 1, 8'hB1, 4'b0010, 2'd1, 1, 2);
        // rr_ptr=2, req=1011 -> owner 3; then wraps to 0
        add(4'b1011, 0, 0, 8'h00, 4'b0000, 2'd1, 0, 1);
        add(4'b1011, 0, 1, 8'hD3, 4'b1000, 2'd3, 1, 4);
        add(4'b1011, 0, 0, 8'h00, 4'b0000, 2'd3, 0, 1);
        // Non-owner requests ignored during owner 0's burst
        add(4'b1111, 0, 1, 8'hA5, 4'b0001, 2'd0, 1, 4);
        // Owner 2 drops after one write, rr_ptr -> 3
        add(4'b0100, 0, 0, 8'h00, 4'b0000, 2'd0, 0, 1);
        add(4'b0100, 0, 1, 8'hC2, 4'b0100, 2'd2, 1, 1);
        add(4'b0000, 0, 0, 8'hC2, 4'b0000, 2'd2, 1, 1);
        add(4'b1001, 0, 0, 8'h00, 4'b0000, 2'd2, 0, 1);
        add(4'b1001, 0, 1, 8'hD3, 4'b1000, 2'd3, 1, 1);

        // Reset state, with a request already present
        reset         = 1'b1;
        bus.req       = 4'b0001;
        bus.req_data  = {dw[3], dw[2], dw[1], dw[0]};
        bus.fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset_state", got_outs(), 16'h0000);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vt.size(); i++) begin
            bus.req       = vt[i].req;
            bus.fifo_full = vt[i].full;
            #1 check($sformatf("row%0d", i), got_outs(),
                     {vt[i].wr, vt[i].data, vt[i].ack, vt[i].owner, vt[i].busy});
            @(negedge clk);
        end

        // Reset mid-burst (owner 3, one write done)
        bus.req = 4'b1000;
        #1 check("pre_reset_burst", got_outs(), {1'b1, 8'hD3, 4'b1000, 2'd3, 1'b1});
        reset = 1'b1;
        #1 check("reset_async_abort", got_outs(), 16'h0000);
        @(negedge clk);
        #1 check("reset_held", got_outs(), 16'h0000);
        reset = 1'b0;
        #1 check("after_release_idle", got_outs(), 16'h0000);
        @(negedge clk);
        #1 check("fresh_scan_owner3", got_outs(), {1'b1, 8'hD3, 4'b1000, 2'd3, 1'b1});

        // Continuous requests from all: 40 cycles from a clean reset
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        bus.req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            #1;
            ph = c % 5;
            g  = (c / 5) % 4;
            og = (c < 5) ? 0 : ((c / 5) - 1) % 4;
            if (ph == 0)
                exp = {1'b0, 8'h00, 4'b0000, 2'(og), 1'b0};
            else
                exp = {1'b1, dw[g], 4'(1 << g), 2'(g), 1'b1};
            check($sformatf("rr_cycle%0d", c), got_outs(), exp);
            for (int k = 0; k < 4; k++)
                if (bus.fifo_wr && bus.ack[k]) wcount[k]++;
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("rr_writes_req%0d", k), 16'(wcount[k]), 16'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
